// File: rtl/picomips_pkg.sv
// Shared types for the picoMIPS switch input path: handshake FSM states and default word width.
package picomips_pkg;

  localparam int DATA_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2
  } state_e;

endpackage

// File: rtl/sw_debounce.sv
// One-bit synchroniser plus debouncer; the accepted level follows the pin after
// SYNC_STAGES+DEBOUNCE_CYCLES cycles, with no backpressure (free-running).
module sw_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_raw,
  output logic o_rise,
  output logic o_level_nxt
);

  localparam int              CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_level;
  logic [CNT_W-1:0]       r_cnt;
  logic                   w_synced;
  logic                   w_differ;
  logic                   w_toggle;

  assign w_synced = r_sync[SYNC_STAGES-1];
  assign w_differ = w_synced ^ r_level;
  assign w_toggle = w_differ && (r_cnt == CNT_LAST);

  // Pulses are valid in the cycle before the edge that flips r_level, so the
  // consumer can act on the same edge the debounced level changes.
  assign o_rise      = w_toggle && w_synced;
  assign o_level_nxt = r_level ^ w_toggle;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync  <= '0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
      if (w_toggle) begin
        r_level <= ~r_level;
      end
      // The count stops at CNT_LAST because reaching it always toggles and clears.
      if (!w_differ || w_toggle) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sw_handshake_port.sv
// Switch data-in port: captures sw_data on a debounced strobe press and holds it with valid/ack.
// Capture lands SYNC_STAGES+DEBOUNCE_CYCLES cycles after the press; the word is held until cpu_ack.
module sw_handshake_port
  import picomips_pkg::*;
#(
  parameter int DATA_W          = DATA_W_DEFAULT,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [DATA_W-1:0] i_sw_data,
  input  logic              i_sw_strobe,
  input  logic              i_cpu_ack,
  output logic [DATA_W-1:0] o_data_out,
  output logic              o_data_valid,
  output logic              o_busy,
  output logic              o_ack_err
);

  logic [DATA_W-1:0] r_data_sync [SYNC_STAGES];
  state_e            r_state;
  logic [DATA_W-1:0] r_data_out;
  logic              r_data_valid;
  logic              r_busy;
  logic              r_ack_err;
  logic              r_ack_run;

  state_e            w_state_nxt;
  logic              w_strb_rise;
  logic              w_strb_lvl_nxt;
  logic              w_capture;
  logic              w_consume;

  sw_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_strb_db (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_raw       (i_sw_strobe),
    .o_rise      (w_strb_rise),
    .o_level_nxt (w_strb_lvl_nxt)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_data_sync[i] <= '0;
      end
    end else begin
      r_data_sync[0] <= i_sw_data;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_data_sync[i] <= r_data_sync[i-1];
      end
    end
  end

  // Strobe decisions use the post-edge debounced level so an ack coinciding
  // with a strobe fall goes straight back to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_consume   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_strb_rise) begin
          w_capture   = 1'b1;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (i_cpu_ack) begin
          w_consume   = 1'b1;
          w_state_nxt = w_strb_lvl_nxt ? RELEASE : IDLE;
        end
      end
      RELEASE: begin
        if (!w_strb_lvl_nxt) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= IDLE;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_ack_err    <= 1'b0;
      r_ack_run    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      if (w_capture) begin
        r_data_out   <= r_data_sync[SYNC_STAGES-1];
        r_data_valid <= 1'b1;
      end else if (w_consume) begin
        r_data_valid <= 1'b0;
      end
      // A held-high ack that already consumed a word is not an error on later cycles.
      r_ack_run <= i_cpu_ack && (w_consume || r_ack_run);
      if (i_cpu_ack && !r_data_valid && !r_ack_run) begin
        r_ack_err <= 1'b1;
      end
    end
  end

  assign o_data_out   = r_data_out;
  assign o_data_valid = r_data_valid;
  assign o_busy       = r_busy;
  assign o_ack_err    = r_ack_err;

endmodule

// File: doc/sw_handshake_port.md
Name: sw_handshake_port

Overview:
- Input-side counterpart to the CPU's LED output path. Conditions the board slide switches and presents them to the CPU core as a one-word data-in port.
- Synchronises and debounces the handshake switch. Captures the data switches on a confirmed handshake press, then holds the word with a valid/ack handshake until the CPU consumes it.
- Sits between the board switch pins and the cpu data-input mux. Driven from the same slow or fast clock as the core.

Parameters:
- DATA_W, 8, width of the data switch word.
- SYNC_STAGES, 2, flip-flop stages in each input synchroniser (legal: 2 or more).
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required before a handshake level change is accepted (legal: 1 or more).

Ports:
- clk  in  1  single system clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sw_data  in  DATA_W  raw data switches, asynchronous to clk.
- sw_strobe  in  1  raw handshake switch, asynchronous to clk.
- cpu_ack  in  1  CPU has read data_out this cycle; pulse.
- data_out  out  DATA_W  captured switch word.
- data_valid  out  1  data_out holds an unconsumed word.
- busy  out  1  high in every state except IDLE; user must release the strobe switch.
- ack_err  out  1  sticky flag: cpu_ack arrived while data_valid was low.

Behaviour:
- Reset is asynchronous and active-low on reset_n. While reset_n is low:
  - data_out=0, data_valid=0, busy=0, ack_err=0.
  - State is IDLE, debounce counter is 0, debounced strobe level is 0, all synchroniser flops are 0.
  - Asserting reset mid-handshake discards any held word immediately.
- Synchronisers:
  - sw_data and sw_strobe each pass through SYNC_STAGES flip-flops.
  - Only synchronised copies are used anywhere downstream.
- Debounce, handshake switch only:
  - Maintain a stable level, strb_db.
  - Each cycle the synced strobe differs from strb_db, the counter increments. Any cycle they match, the counter clears.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, strb_db toggles on the next edge and the counter clears.
  - Result: a clean edge is accepted DEBOUNCE_CYCLES cycles after the synced input settles. Total latency from the pin is SYNC_STAGES+DEBOUNCE_CYCLES cycles.
  - A glitch shorter than DEBOUNCE_CYCLES causes no change.
  - The counter saturates and never wraps.
- State machine (states IDLE, HOLD, RELEASE):
  - IDLE -> HOLD on the strb_db 0->1 transition. On the same edge: data_out <= synced sw_data, data_valid <= 1.
  - HOLD: data_valid=1 and data_out is frozen; sw_data changes are ignored.
  - HOLD, on cpu_ack=1: data_valid <= 0 on the next edge. Next state is RELEASE if strb_db=1, else IDLE.
  - RELEASE: wait for strb_db=0, then go to IDLE. A strobe rising edge cannot occur while in RELEASE.
  - If strb_db falls while in HOLD, stay in HOLD until ack, then go directly to IDLE.
- Handshake rules:
  - data_out changes only on an IDLE->HOLD edge or at reset.
  - One capture per switch press: holding the strobe high never recaptures.
  - cpu_ack asserted for several cycles consumes exactly one word; the extra cycles are ignored without setting ack_err.
  - cpu_ack while data_valid=0 and the state is not the ack-consuming edge sets ack_err=1. ack_err clears only on reset.
- Simultaneous events: cpu_ack and a strobe fall in the same cycle in HOLD -> IDLE, data_valid=0.
- busy is a registered state decode, so it has no combinational path from the inputs.

Decomposition:
- Shared package picomips_pkg holds the state enum (IDLE, HOLD, RELEASE) and DATA_W_DEFAULT=8.
- One sub-module, sw_debounce: synchroniser plus debounce counter for one bit, parameterised by SYNC_STAGES and DEBOUNCE_CYCLES.
- The data path reuses only a plain DATA_W-wide synchroniser inside the top block.

Test Plan:
- Reset:
  - Stimulus: reset_n=0 for 3 cycles with sw_data=8'hFF and sw_strobe=1, then release reset.
  - Required: all outputs 0 during reset. data_valid goes high exactly 2+4=6 cycles after reset release, with data_out=8'hFF.
- Normal transfer:
  - Stimulus: sw_data=8'h5A, strobe raised and held 10 cycles; then cpu_ack for 1 cycle; then strobe lowered.
  - Required: data_out=8'h5A with data_valid=1 at cycle 6. data_valid=0 one cycle after ack. busy falls 6 cycles after strobe low.
- Bounce rejection:
  - Stimulus: strobe pulses 1-3 cycles long, 3 cycles apart, then a stable high.
  - Required: no capture during the pulses; exactly one capture after the stable high.
- Data freeze:
  - Stimulus: while in HOLD, change sw_data from 8'h5A to 8'hC3.
  - Required: data_out stays 8'h5A. After release and a new press, data_out=8'hC3.
- Ack errors:
  - Stimulus: cpu_ack in IDLE; separately, a 5-cycle cpu_ack in HOLD.
  - Required: ack_err=1 for the IDLE case. The long ack consumes exactly one word and leaves ack_err=0 if it was 0 before.
- Mid-operation reset:
  - Stimulus: assert reset_n=0 while in HOLD.
  - Required: data_valid and busy go to 0 asynchronously, within the same cycle.
